// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: decode-side inputs and hazard/forwarding controls
interface hazard_forward_ctrl_if #(parameter int CNT_W = 16);
  logic             id_valid;
  logic [3:0]       id_op;
  logic [2:0]       id_sr1;
  logic [2:0]       id_sr2;
  logic             id_uses_sr1;
  logic             id_uses_sr2;
  logic [2:0]       id_dest;
  logic             id_writes;
  logic             dmem_stall;
  logic             flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall_id;
  logic             bubble_ex;
  logic             freeze;
  logic [CNT_W-1:0] bubble_count;
  logic             fwd_conflict;
  modport master (
    output id_valid, id_op, id_sr1, id_sr2, id_uses_sr1, id_uses_sr2, id_dest, id_writes, dmem_stall, flush,
    input  fwd_a_sel, fwd_b_sel, stall_id, bubble_ex, freeze, bubble_count, fwd_conflict
  );
  modport slave (
    input  id_valid, id_op, id_sr1, id_sr2, id_uses_sr1, id_uses_sr2, id_dest, id_writes, dmem_stall, flush,
    output fwd_a_sel, fwd_b_sel, stall_id, bubble_ex, freeze, bubble_count, fwd_conflict
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: LC-3b EX operand forwarding and load-use/dmem/flush pipeline control
module hazard_forward_ctrl #(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  hazard_forward_ctrl_if.slave bus
);
  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       writes;
    logic       load;
  } prod_t;
  typedef struct packed {
    prod_t      p;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       use1;
    logic       use2;
  } ex_t;
  typedef struct packed {
    logic       valid;
    logic [2:0] dest;
    logic       writes;
  } wb_t;
  ex_t              ex_q, ex_d, id_ex;
  prod_t            mem_q, mem_d;
  wb_t              wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_load, load_use, hold, bubble;
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [2:0] src, input prod_t mem, input wb_t wb);
    return !use_src ? 2'b00 :
           (mem.valid & mem.writes & ~mem.load & (mem.dest == src)) ? 2'b01 :
           (wb.valid & wb.writes & (wb.dest == src)) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    id_load  = bus.id_op inside {4'd2, 4'd6, 4'd10};
    id_ex    = {bus.id_valid, bus.id_dest, bus.id_writes, id_load,
                bus.id_sr1, bus.id_sr2, bus.id_uses_sr1, bus.id_uses_sr2};
    load_use = bus.id_valid & ex_q.p.valid & ex_q.p.load & ex_q.p.writes &
               ((bus.id_uses_sr1 & (bus.id_sr1 == ex_q.p.dest)) | (bus.id_uses_sr2 & (bus.id_sr2 == ex_q.p.dest)));
    hold     = bus.dmem_stall;
    bubble   = ~hold & ~bus.flush & load_use;
    ex_d     = hold ? ex_q : (bus.flush | load_use) ? '0 : id_ex;
    mem_d    = hold ? mem_q : ex_q.p;
    if (bus.flush & ~hold) mem_d.valid = 1'b0;
    wb_d     = hold ? wb_q : {mem_q.valid, mem_q.dest, mem_q.writes};
    cnt_d    = (bubble & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.fwd_a_sel    = fwd_sel(ex_q.use1, ex_q.sr1, mem_q, wb_q);
  assign bus.fwd_b_sel    = fwd_sel(ex_q.use2, ex_q.sr2, mem_q, wb_q);
  assign bus.freeze       = reset_n & hold;
  assign bus.stall_id     = reset_n & (hold | bubble);
  assign bus.bubble_ex    = reset_n & bubble;
  assign bus.bubble_count = cnt_q;
  assign bus.fwd_conflict = ex_q.p.valid & mem_q.valid & mem_q.writes & mem_q.load &
                            ((ex_q.use1 & (ex_q.sr1 == mem_q.dest)) | (ex_q.use2 & (ex_q.sr2 == mem_q.dest)));
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed scenarios for forwarding, load-use, dmem stall, flush and saturation
module tb_hazard_forward_ctrl;
  localparam int CW = 2;
  localparam logic [3:0] OP_ADD = 4'd1, OP_LDB = 4'd2, OP_LDR = 4'd6, OP_LDI = 4'd10;
  logic clk = 1'b0;
  logic reset_n;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  hazard_forward_ctrl_if #(.CNT_W(CW)) bif ();
  hazard_forward_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bif));
  always #5 clk = ~clk;
  task automatic id(input logic v, input logic [3:0] op, input logic [2:0] s1, input logic u1,
                    input logic [2:0] s2, input logic u2, input logic [2:0] d, input logic w);
    bif.id_valid = v;
    bif.id_op = op;
    bif.id_sr1 = s1;
    bif.id_uses_sr1 = u1;
    bif.id_sr2 = s2;
    bif.id_uses_sr2 = u2;
    bif.id_dest = d;
    bif.id_writes = w;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    bif.dmem_stall = 1'b0;
    bif.flush = 1'b0;
    id(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    total++; if (bif.fwd_a_sel !== 2'b00) begin bad++; $display("FAIL reset_fwd_a got=%0d want=0", bif.fwd_a_sel); end
    total++; if (bif.fwd_b_sel !== 2'b00) begin bad++; $display("FAIL reset_fwd_b got=%0d want=0", bif.fwd_b_sel); end
    total++; if (bif.stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0d want=0", bif.stall_id); end
    total++; if (bif.bubble_ex !== 1'b0) begin bad++; $display("FAIL reset_bubble got=%0d want=0", bif.bubble_ex); end
    total++; if (bif.freeze !== 1'b0) begin bad++; $display("FAIL reset_freeze got=%0d want=0", bif.freeze); end
    total++; if (bif.bubble_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bif.bubble_count); end
    total++; if (bif.fwd_conflict !== 1'b0) begin bad++; $display("FAIL reset_conflict got=%0d want=0", bif.fwd_conflict); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask
  task automatic test_alu_forward();
    id(1, OP_ADD, 3'd5, 1, 3'd6, 1, 3'd1, 1);
    step();
    id(1, OP_ADD, 3'd1, 1, 3'd7, 1, 3'd2, 1);
    #1;
    total++; if (bif.stall_id !== 1'b0) begin bad++; $display("FAIL alu_no_stall got=%0d want=0", bif.stall_id); end
    step();
    id(1, OP_ADD, 3'd1, 1, 3'd0, 0, 3'd3, 1);
    #1;
    total++; if (bif.fwd_a_sel !== 2'b01) begin bad++; $display("FAIL alu_mem_fwd_a got=%0d want=1", bif.fwd_a_sel); end
    total++; if (bif.fwd_b_sel !== 2'b00) begin bad++; $display("FAIL alu_mem_fwd_b got=%0d want=0", bif.fwd_b_sel); end
    step();
    total++; if (bif.fwd_a_sel !== 2'b10) begin bad++; $display("FAIL alu_wb_fwd_a got=%0d want=2", bif.fwd_a_sel); end
    drain();
  endtask
  task automatic test_load_use();
    id(1, OP_LDR, 3'd3, 1, 3'd0, 0, 3'd2, 1);
    step();
    id(1, OP_ADD, 3'd5, 1, 3'd2, 1, 3'd4, 1);
    #1;
    total++; if (bif.stall_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0d want=1", bif.stall_id); end
    total++; if (bif.bubble_ex !== 1'b1) begin bad++; $display("FAIL lu_bubble got=%0d want=1", bif.bubble_ex); end
    total++; if (bif.freeze !== 1'b0) begin bad++; $display("FAIL lu_freeze got=%0d want=0", bif.freeze); end
    step();
    exp_cnt = 1;
    total++; if (bif.bubble_count !== CW'(exp_cnt)) begin bad++; $display("FAIL lu_count got=%0d want=%0d", bif.bubble_count, exp_cnt); end
    total++; if (bif.stall_id !== 1'b0) begin bad++; $display("FAIL lu_one_cycle got=%0d want=0", bif.stall_id); end
    total++; if (bif.fwd_conflict !== 1'b0) begin bad++; $display("FAIL lu_conflict_bubble got=%0d want=0", bif.fwd_conflict); end
    step();
    total++; if (bif.fwd_b_sel !== 2'b10) begin bad++; $display("FAIL lu_fwd_b got=%0d want=2", bif.fwd_b_sel); end
    total++; if (bif.fwd_a_sel !== 2'b00) begin bad++; $display("FAIL lu_fwd_a got=%0d want=0", bif.fwd_a_sel); end
    total++; if (bif.fwd_conflict !== 1'b0) begin bad++; $display("FAIL lu_conflict got=%0d want=0", bif.fwd_conflict); end
    drain();
  endtask
  task automatic test_dmem_stall();
    id(1, OP_LDB, 3'd0, 0, 3'd0, 0, 3'd6, 1);
    step();
    id(1, OP_ADD, 3'd6, 1, 3'd1, 0, 3'd7, 1);
    bif.dmem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bif.freeze !== 1'b1) begin bad++; $display("FAIL dm_freeze[%0d] got=%0d want=1", i, bif.freeze); end
      total++; if (bif.stall_id !== 1'b1) begin bad++; $display("FAIL dm_stall[%0d] got=%0d want=1", i, bif.stall_id); end
      total++; if (bif.bubble_ex !== 1'b0) begin bad++; $display("FAIL dm_bubble[%0d] got=%0d want=0", i, bif.bubble_ex); end
      total++; if (bif.bubble_count !== CW'(exp_cnt)) begin bad++; $display("FAIL dm_count_hold[%0d] got=%0d want=%0d", i, bif.bubble_count, exp_cnt); end
      step();
    end
    bif.dmem_stall = 1'b0;
    #1;
    total++; if (bif.bubble_ex !== 1'b1) begin bad++; $display("FAIL dm_after_bubble got=%0d want=1", bif.bubble_ex); end
    total++; if (bif.freeze !== 1'b0) begin bad++; $display("FAIL dm_after_freeze got=%0d want=0", bif.freeze); end
    step();
    exp_cnt = 2;
    total++; if (bif.bubble_count !== CW'(exp_cnt)) begin bad++; $display("FAIL dm_count got=%0d want=%0d", bif.bubble_count, exp_cnt); end
    total++; if (bif.bubble_ex !== 1'b0) begin bad++; $display("FAIL dm_single_bubble got=%0d want=0", bif.bubble_ex); end
    step();
    total++; if (bif.fwd_a_sel !== 2'b10) begin bad++; $display("FAIL dm_fwd_a got=%0d want=2", bif.fwd_a_sel); end
    drain();
  endtask
  task automatic test_flush();
    id(1, OP_ADD, 3'd0, 0, 3'd0, 0, 3'd3, 1);
    step();
    bif.flush = 1'b1;
    id(1, OP_ADD, 3'd3, 1, 3'd0, 0, 3'd5, 1);
    #1;
    total++; if (bif.stall_id !== 1'b0) begin bad++; $display("FAIL fl_alu_stall got=%0d want=0", bif.stall_id); end
    step();
    bif.flush = 1'b0;
    step();
    total++; if (bif.fwd_a_sel !== 2'b00) begin bad++; $display("FAIL fl_alu_fwd_a got=%0d want=0", bif.fwd_a_sel); end
    drain();
    id(1, OP_LDI, 3'd0, 0, 3'd0, 0, 3'd3, 1);
    step();
    bif.flush = 1'b1;
    id(1, OP_ADD, 3'd0, 0, 3'd3, 1, 3'd5, 1);
    #1;
    total++; if (bif.stall_id !== 1'b0) begin bad++; $display("FAIL fl_lu_stall got=%0d want=0", bif.stall_id); end
    total++; if (bif.bubble_ex !== 1'b0) begin bad++; $display("FAIL fl_lu_bubble got=%0d want=0", bif.bubble_ex); end
    step();
    bif.flush = 1'b0;
    #1;
    total++; if (bif.stall_id !== 1'b0) begin bad++; $display("FAIL fl_after_stall got=%0d want=0", bif.stall_id); end
    total++; if (bif.bubble_count !== CW'(exp_cnt)) begin bad++; $display("FAIL fl_count got=%0d want=%0d", bif.bubble_count, exp_cnt); end
    step();
    total++; if (bif.fwd_b_sel !== 2'b00) begin bad++; $display("FAIL fl_lu_fwd_b got=%0d want=0", bif.fwd_b_sel); end
    drain();
  endtask
  task automatic test_priority();
    id(1, OP_ADD, 3'd0, 0, 3'd0, 0, 3'd4, 1);
    step();
    step();
    id(1, OP_ADD, 3'd4, 1, 3'd0, 0, 3'd5, 1);
    step();
    total++; if (bif.fwd_a_sel !== 2'b01) begin bad++; $display("FAIL pri_mem_over_wb got=%0d want=1", bif.fwd_a_sel); end
    drain();
    id(1, OP_ADD, 3'd0, 0, 3'd0, 0, 3'd4, 1);
    step();
    step();
    id(1, OP_ADD, 3'd4, 0, 3'd4, 1, 3'd6, 1);
    step();
    total++; if (bif.fwd_a_sel !== 2'b00) begin bad++; $display("FAIL pri_unused_a got=%0d want=0", bif.fwd_a_sel); end
    total++; if (bif.fwd_b_sel !== 2'b01) begin bad++; $display("FAIL pri_mem_b got=%0d want=1", bif.fwd_b_sel); end
    drain();
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      id(1, OP_LDR, 3'd0, 0, 3'd0, 0, 3'd1, 1);
      step();
      id(1, OP_ADD, 3'd1, 1, 3'd0, 0, 3'd2, 1);
      #1;
      total++; if (bif.bubble_ex !== 1'b1) begin bad++; $display("FAIL sat_bubble[%0d] got=%0d want=1", i, bif.bubble_ex); end
      step();
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      total++; if (bif.bubble_count !== CW'(exp_cnt)) begin bad++; $display("FAIL sat_count[%0d] got=%0d want=%0d", i, bif.bubble_count, exp_cnt); end
      id(0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask
  task automatic test_reset_mid_stall();
    id(1, OP_LDR, 3'd0, 0, 3'd0, 0, 3'd1, 1);
    step();
    id(1, OP_ADD, 3'd1, 1, 3'd0, 0, 3'd2, 1);
    bif.dmem_stall = 1'b1;
    #1;
    total++; if (bif.freeze !== 1'b1) begin bad++; $display("FAIL rm_pre_freeze got=%0d want=1", bif.freeze); end
    reset_n = 1'b0;
    #1;
    total++; if (bif.freeze !== 1'b0) begin bad++; $display("FAIL rm_freeze got=%0d want=0", bif.freeze); end
    total++; if (bif.stall_id !== 1'b0) begin bad++; $display("FAIL rm_stall got=%0d want=0", bif.stall_id); end
    total++; if (bif.bubble_ex !== 1'b0) begin bad++; $display("FAIL rm_bubble got=%0d want=0", bif.bubble_ex); end
    total++; if (bif.bubble_count !== 2'd0) begin bad++; $display("FAIL rm_count got=%0d want=0", bif.bubble_count); end
    total++; if (bif.fwd_a_sel !== 2'b00) begin bad++; $display("FAIL rm_fwd_a got=%0d want=0", bif.fwd_a_sel); end
    bif.dmem_stall = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    total++; if (bif.stall_id !== 1'b0) begin bad++; $display("FAIL rm_no_pending_stall got=%0d want=0", bif.stall_id); end
    step();
    total++; if (bif.bubble_count !== 2'd0) begin bad++; $display("FAIL rm_no_pending_count got=%0d want=0", bif.bubble_count); end
  endtask
  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_dmem_stall();
    test_flush();
    test_priority();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Hazard and forwarding controller for the LC-3b five-stage pipeline. It tracks the destination register, write-enable and load status of the instructions in EX, MEM and WB. It drives the two EX-stage operand forwarding selects and the load-use stall/bubble controls. It freezes its own tracking on data-memory stalls and invalidates wrong-path instructions on a taken-branch flush. It sits beside the decode stage and feeds the EX operand muxes and the IF/ID/EX pipeline-register enables.

## Interface
Parameters:
- CNT_W, 16, width of the saturating load-use bubble counter

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_op  in  4  ID opcode (lc3b_opcode encoding)
- id_sr1, id_sr2  in  3 each  ID source registers
- id_uses_sr1, id_uses_sr2  in  1 each  the source is actually read
- id_dest  in  3  ID destination register
- id_writes  in  1  ID writes the register file
- dmem_stall  in  1  MEM stage is waiting on data memory
- flush  in  1  taken branch/jump resolved in MEM
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 regfile, 01 MEM-stage result, 10 WB-stage result
- stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX register
- freeze  out  1  hold all pipeline registers
- bubble_count  out  CNT_W  number of load-use bubbles inserted, saturating
- fwd_conflict  out  1  debug flag: EX operand matches a load still in MEM

## Operation
- Tracking registers per stage S in {EX, MEM, WB}: S_valid, S_dest[2:0], S_writes, S_load. EX also holds ex_sr1, ex_sr2, ex_use1, ex_use2.
- Loads are op_ldb, op_ldr and op_ldi. S_load is set only for these opcodes.
- Forwarding for operand A (B is identical, using sr2/use2), combinational from the tracking registers. Priority order:
  - 01 if ex_use1 & MEM_valid & MEM_writes & ~MEM_load & MEM_dest==ex_sr1.
  - else 10 if ex_use1 & WB_valid & WB_writes & WB_dest==ex_sr1.
  - else 00.
  - The MEM stage has priority because it is the newer producer.
  - R0 is a normal register and gets no special case.
- fwd_conflict = ex_valid and either used source matches a valid, writing MEM-stage load. The select then falls through to the WB check. This flag must never assert with correct stall logic.
- load_use = id_valid & EX_valid & EX_load & EX_writes & ((id_uses_sr1 & id_sr1==EX_dest) | (id_uses_sr2 & id_sr2==EX_dest)).
- Priority each cycle is dmem_stall > flush > load_use > normal.
  - dmem_stall: freeze=1, stall_id=1, bubble_ex=0. All tracking registers and the counter hold.
  - flush: EX and MEM tracking both become invalid: the next MEM state is the current EX entry invalidated, and the next EX entry is invalid. WB <= MEM (the branch itself). load_use is ignored. stall_id=0, bubble_ex=0.
  - load_use: stall_id=1, bubble_ex=1. Next EX is invalid (all fields 0), MEM <= EX, WB <= MEM. bubble_count increments, saturating at all-ones.
  - normal: EX <= ID fields (valid = id_valid), MEM <= EX, WB <= MEM.
- WB retires each cycle unless the pipe is frozen.

## Timing
- Reset (reset_n low, asynchronous): all valid bits, dest and flag fields, and bubble_count go to 0.
  - Outputs during and after reset until the first ID capture: fwd selects 00, stall_id=0, bubble_ex=0, freeze=0, fwd_conflict=0.
- Forward selects and fwd_conflict are combinational from registers, with zero added latency relative to the EX stage.
- stall_id, bubble_ex and freeze are combinational from ID inputs, tracking state and dmem_stall. They must settle in the same cycle.
- A load-use hazard costs exactly one bubble. The cycle after the stall, the load is in WB and the consumer is in EX with sel=10.
- A dmem_stall arriving in the same cycle as load_use: freeze wins, no bubble is inserted, and the counter holds. load_use is re-evaluated after the stall ends.
- flush arriving in the same cycle as dmem_stall: the flush is ignored that cycle. The MEM stage must re-present flush after the stall.
- Asserting reset mid-stall clears all state immediately, with no pending bubble.
- bubble_count at all-ones stays at all-ones.

## Test plan
- ADD R1 in EX, then ADD using R1 as sr1 in ID -> the next cycle fwd_a_sel=01. One cycle later, a second consumer of R1 gets fwd_a_sel=10.
- LDR R2 in EX, ADD sr2=R2 in ID -> stall_id=1 and bubble_ex=1 for exactly one cycle, bubble_count 0->1. Next cycle fwd_b_sel=10 and fwd_conflict=0.
- Same load-use case with dmem_stall=1 for 3 cycles -> freeze=1 and bubble_ex=0 during those cycles. The bubble is inserted on the first non-stall cycle, and the count increments only once.
- flush while an ADD R3 is in EX -> MEM_valid becomes 0. A later consumer of R3 gets sel=00, and no stall occurs even if load_use was true.
- Producers writing R4 in both MEM and WB, consumer sr1=R4 -> sel=01. With id_uses_sr1=0 -> sel=00.
- Preload the counter near saturation (CNT_W=2) and force 5 load-use bubbles -> the count sticks at 3. Assert reset_n low mid-stall -> all outputs 0 asynchronously.
